spi_slave: RTL
==============

# spi_slave

SPI slave endpoint that sits directly downstream of the `master` block on the same board-level SPI link (CS, SCLK, MOSI, MISO), for loopback and self-test of the master in the FPGA. It oversamples the link on the system clock, deserialises MOSI into `SIZE`-bit words for the fabric, and serialises a software-supplied response word onto MISO. Data format is SPI mode 0 (CPOL=0, CPHA=0), MSB first, CS active low.

## Interface
- `SIZE`, 8: word width in bits (≥2).
- `clk` in 1: system clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `CS` in 1: chip select from the master, active low, asynchronous to `clk`.
- `SCLK` in 1: serial clock from the master, idle low, asynchronous to `clk`.
- `MOSI` in 1: serial data from the master.
- `MISO` out 1: serial data to the master; always driven, 0 when idle.
- `tx_data_i` in SIZE: response word to send.
- `tx_load_i` in 1: write strobe for `tx_data_i`; accepted only when `tx_ready_o`=1.
- `tx_ready_o` out 1: TX holding buffer empty.
- `rx_data_o` out SIZE: last complete received word; held until the next word completes.
- `rx_valid_o` out 1: one-cycle pulse, `rx_data_o` updated.
- `busy_o` out 1: frame in progress (state SHIFT).
- `tx_underrun_o` out 1: one-cycle pulse, word started with TX buffer empty.
- `frame_err_o` out 1: one-cycle pulse, CS released mid-word.

## Operation
- Input sync: CS, SCLK, MOSI each pass two flops; one further flop on SCLK and CS for edge detection. `sclk_rise`/`sclk_fall`/`cs_fall`/`cs_rise` are single-cycle strobes from synced signals.
- TX holding buffer: `tx_load_i`&`tx_ready_o` captures `tx_data_i`, `tx_ready_o`→0 next cycle. Load while `tx_ready_o`=0 ignored. Buffer consumed at each word start; `tx_ready_o`→1 the next cycle.
- Word start (on `cs_fall`, and on the first `sclk_fall` after a completed word while CS low): TX shift reg ← buffer if full, else all zeros plus `tx_underrun_o` pulse. MISO = shift reg MSB, registered.
- States IDLE, SHIFT. IDLE→SHIFT on `cs_fall`; SHIFT→IDLE on `cs_rise`.
- SHIFT, `sclk_rise`: rx shift ← {rx[SIZE-2:0], MOSI_sync}; bit counter +1 (width clog2(SIZE+1)).
- SHIFT, `sclk_fall` with counter ≠ 0 and ≠ SIZE: TX shift left, MISO ← new MSB.
- Counter reaches SIZE: `rx_data_o` ← assembled word, `rx_valid_o` pulse, counter → 0, next `sclk_fall` is a word start. Back-to-back words under one CS supported indefinitely.
- `cs_rise` with counter = 0: clean end, no flags. Counter ≠ 0: partial word discarded, `rx_data_o` unchanged, `frame_err_o` pulse. TX buffer contents kept if not yet consumed.
- Same-cycle load and consume with buffer empty: shift reg takes zeros (underrun), buffer captures the new word.
- `rst` mid-frame: everything cleared; frame resumes only on a fresh `cs_fall`.

## Timing
- Reset values: MISO 0, `tx_ready_o` 1, `rx_data_o` 0, `rx_valid_o` 0, `busy_o` 0, `tx_underrun_o` 0, `frame_err_o` 0; state IDLE, counter 0, buffers 0.
- SCLK pin edge → internal strobe: 3 clk. Strobe → `rx_valid_o`/`rx_data_o`: 1 clk (4 clk from SIZE-th SCLK rising edge).
- `cs_fall` strobe → MISO MSB valid: 1 clk (4 clk after pin).
- `sclk_fall` strobe → next MISO bit: 1 clk.
- Link constraint: SCLK high and low phases each ≥4 clk; CS low to first SCLK rise ≥4 clk. The `master` divider setting must respect this.
- `busy_o` high from 1 clk after `cs_fall` strobe until 1 clk after `cs_rise` strobe.

## Test plan
- Reset: assert `rst` 2 cycles mid-frame → all outputs at reset values, `tx_ready_o`=1, no `rx_valid_o` from the aborted frame.
- Single word: load 0xA5, master sends 0x55 → MISO shifts 1,0,1,0,0,1,0,1; one `rx_valid_o` with `rx_data_o`=0x55; `tx_ready_o` back to 1.
- Back-to-back: loads 0x3C then 0xC3 (second after `tx_ready_o` reasserts), master sends 0x01,0x80 under one CS → two `rx_valid_o` pulses with 0x01, 0x80; MISO carries 0x3C then 0xC3.
- Underrun: no load, master sends 0xFF → MISO all zeros, one `tx_underrun_o` pulse, `rx_data_o`=0xFF.
- Abort: CS released after 5 bits of 0x96 → `frame_err_o` one pulse, no `rx_valid_o`, `rx_data_o` keeps previous value, `busy_o`→0.
- Load ignored: two `tx_load_i` (0x11, 0x22) on consecutive cycles → buffer holds 0x11, next word transmits 0x11.

Source files
------------

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - SPI mode-0 slave endpoint: oversampled link, RX word deserialiser, buffered TX serialiser
// Loopback/self-test partner for the SPI master; MSB first, CS active low.
module spi_slave #(
  parameter int SIZE = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            CS,
  input  logic            SCLK,
  input  logic            MOSI,
  output logic            MISO,
  input  logic [SIZE-1:0] tx_data_i,
  input  logic            tx_load_i,
  output logic            tx_ready_o,
  output logic [SIZE-1:0] rx_data_o,
  output logic            rx_valid_o,
  output logic            busy_o,
  output logic            tx_underrun_o,
  output logic            frame_err_o
);

  localparam int CW = $clog2(SIZE + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  logic [2:0] cs_q, sclk_q;
  logic [1:0] mosi_q;

  // Sync flops clear to 0 so a CS already low at reset release never looks like a fresh cs_fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_q   <= '0;
      sclk_q <= '0;
      mosi_q <= '0;
    end else begin
      cs_q   <= {cs_q[1:0], CS};
      sclk_q <= {sclk_q[1:0], SCLK};
      mosi_q <= {mosi_q[0], MOSI};
    end
  end

  logic cs_fall, cs_rise, sclk_rise, sclk_fall, mosi_sync;
  assign cs_fall   =  cs_q[2]   & ~cs_q[1];
  assign cs_rise   = ~cs_q[2]   &  cs_q[1];
  assign sclk_rise = ~sclk_q[2] &  sclk_q[1];
  assign sclk_fall =  sclk_q[2] & ~sclk_q[1];
  assign mosi_sync =  mosi_q[1];

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SIZE-1:0] rx_shift_q, rx_shift_d;
  logic [SIZE-1:0] tx_shift_q, tx_shift_d;
  logic [SIZE-1:0] tx_buf_q, tx_buf_d;
  logic            tx_full_q, tx_full_d;
  logic [SIZE-1:0] rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            underrun_q, underrun_d;
  logic            ferr_q, ferr_d;
  logic            miso_q, miso_d;
  logic            word_start;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rx_shift_q <= '0;
      tx_shift_q <= '0;
      tx_buf_q   <= '0;
      tx_full_q  <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      underrun_q <= 1'b0;
      ferr_q     <= 1'b0;
      miso_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rx_shift_q <= rx_shift_d;
      tx_shift_q <= tx_shift_d;
      tx_buf_q   <= tx_buf_d;
      tx_full_q  <= tx_full_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      underrun_q <= underrun_d;
      ferr_q     <= ferr_d;
      miso_q     <= miso_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    tx_buf_d   = tx_buf_q;
    tx_full_d  = tx_full_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    underrun_d = 1'b0;
    ferr_d     = 1'b0;
    miso_d     = miso_q;
    word_start = 1'b0;

    case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        if (cs_fall) begin
          state_d    = SHIFT;
          cnt_d      = '0;
          rx_shift_d = '0;
          word_start = 1'b1;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_d = IDLE;
          cnt_d   = '0;
          miso_d  = 1'b0;
          ferr_d  = (cnt_q != '0);
        end else begin
          if (sclk_rise) begin
            rx_shift_d = {rx_shift_q[SIZE-2:0], mosi_sync};
            if (cnt_q == CW'(SIZE - 1)) begin
              rx_data_d  = {rx_shift_q[SIZE-2:0], mosi_sync};
              rx_valid_d = 1'b1;
              cnt_d      = '0;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
          // A falling edge with the counter at 0 follows a completed word and starts the next one.
          if (sclk_fall) begin
            if (cnt_q == '0) begin
              word_start = 1'b1;
            end else begin
              tx_shift_d = {tx_shift_q[SIZE-2:0], 1'b0};
              miso_d     = tx_shift_q[SIZE-2];
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (word_start) begin
      if (tx_full_q) begin
        tx_shift_d = tx_buf_q;
        tx_full_d  = 1'b0;
        miso_d     = tx_buf_q[SIZE-1];
      end else begin
        tx_shift_d = '0;
        underrun_d = 1'b1;
        miso_d     = 1'b0;
      end
    end

    // Acceptance uses the registered ready, so a load racing an empty-buffer consume still lands.
    if (tx_load_i && !tx_full_q) begin
      tx_buf_d  = tx_data_i;
      tx_full_d = 1'b1;
    end
  end

  assign MISO          = miso_q;
  assign tx_ready_o    = ~tx_full_q;
  assign rx_data_o     = rx_data_q;
  assign rx_valid_o    = rx_valid_q;
  assign busy_o        = (state_q == SHIFT);
  assign tx_underrun_o = underrun_q;
  assign frame_err_o   = ferr_q;

endmodule
